// File: rtl/instr_byte_queue.sv
// ============================================================================
//  Module      : instr_byte_queue
//  Description : Circular byte queue between 8-byte fetch chunks and a
//                variable-length instruction decoder window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_byte_queue #(
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_valid,
    input  logic [63:0]   fetch_data,
    output logic          fetch_ready,
    output logic [127:0]  window,
    output logic [5:0]    window_count,
    output logic [63:0]   instr_pc,
    input  logic          consume_valid,
    input  logic [3:0]    consume_len,
    input  logic          flush,
    input  logic [63:0]   flush_pc,
    output logic          err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_READY_MAX = CW'(DEPTH - 8);
    localparam logic [CW-1:0] C_WIN_BYTES = CW'(16);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   pc_q, pc_d;
    logic          err_q, err_d;

    logic          w_enq;
    logic          w_legal;
    logic          w_illegal;
    logic [5:0]    w_wcnt;

    // Ready depends only on registered occupancy so it never waits on consume.
    assign fetch_ready = (count_q <= C_READY_MAX) && !flush;
    assign w_enq       = fetch_valid && fetch_ready;

    assign w_wcnt    = (count_q > C_WIN_BYTES) ? 6'd16 : 6'(count_q);
    assign w_legal   = consume_valid && (consume_len != 4'd0) &&
                       ({2'b00, consume_len} <= w_wcnt);
    assign w_illegal = consume_valid && !w_legal;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        err_d   = err_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = flush_pc;
        end else begin
            if (w_enq) begin
                tail_d = tail_q + AW'(8);
            end
            if (w_legal) begin
                head_d = head_q + AW'(consume_len);
                pc_d   = pc_q + 64'(consume_len);
            end
            if (w_illegal) begin
                err_d = 1'b1;
            end
            count_d = count_q + (w_enq ? CW'(8) : CW'(0))
                              - (w_legal ? CW'(consume_len) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Storage is never reset; it only changes on an accepted chunk.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            for (int b = 0; b < 8; b++) begin
                mem_q[tail_q + AW'(b)] <= fetch_data[8*b +: 8];
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_window
        logic [AW-1:0] w_idx;
        assign w_idx = head_q + AW'(i);
        assign window[127-8*i -: 8] = (6'(i) < w_wcnt) ? mem_q[w_idx] : 8'h00;
    end

    assign window_count = w_wcnt;
    assign instr_pc     = pc_q;
    assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_byte_queue.sv
// ============================================================================
//  Module      : tb_instr_byte_queue
//  Description : Self-checking bench for instr_byte_queue against a
//                byte-level queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_byte_queue;

    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_valid = 1'b0;
    logic [63:0]   fetch_data = '0;
    logic          fetch_ready;
    logic [127:0]  window;
    logic [5:0]    window_count;
    logic [63:0]   instr_pc;
    logic          consume_valid = 1'b0;
    logic [3:0]    consume_len = '0;
    logic          flush = 1'b0;
    logic [63:0]   flush_pc = '0;
    logic          err;

    instr_byte_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_data    (fetch_data),
        .fetch_ready   (fetch_ready),
        .window        (window),
        .window_count  (window_count),
        .instr_pc      (instr_pc),
        .consume_valid (consume_valid),
        .consume_len   (consume_len),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Reference model: plain byte queue, oldest byte at index 0.
    logic [7:0]  mq [$];
    logic [63:0] m_pc  = '0;
    logic        m_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] exp_window();
        logic [127:0] w = '0;
        for (int i = 0; i < 16; i++)
            if (i < mq.size()) w[127-8*i -: 8] = mq[i];
        return w;
    endfunction

    function automatic int exp_wcnt();
        return (mq.size() > 16) ? 16 : mq.size();
    endfunction

    always @(negedge clk)
        if (!reset)
            assert (dut.count_q <= DEPTH)
            else $error("FAIL count_bound: got %0d expected <= %0d", dut.count_q, DEPTH);

    task automatic cycle(input logic rst, input logic fv, input logic [63:0] fd,
                         input logic cv, input logic [3:0] cl,
                         input logic fl, input logic [63:0] fpc);
        logic exp_rdy;
        int   wc;
        reset = rst; fetch_valid = fv; fetch_data = fd;
        consume_valid = cv; consume_len = cl; flush = fl; flush_pc = fpc;
        exp_rdy = !fl && ((DEPTH - mq.size()) >= 8);
        #1;
        if (!rst) check_eq("fetch_ready", 128'(fetch_ready), 128'(exp_rdy));
        if (rst) begin
            mq.delete(); m_pc = '0; m_err = 1'b0;
        end else if (fl) begin
            mq.delete(); m_pc = fpc;
        end else begin
            wc = exp_wcnt();
            if (cv) begin
                if (cl != 0 && int'(cl) <= wc) begin
                    for (int k = 0; k < int'(cl); k++) void'(mq.pop_front());
                    m_pc = m_pc + 64'(cl);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (fv && exp_rdy)
                for (int b = 0; b < 8; b++) mq.push_back(fd[8*b +: 8]);
        end
        @(posedge clk); #1;
        check_eq("window", window, exp_window());
        check_eq("window_count", 128'(window_count), 128'(exp_wcnt()));
        check_eq("instr_pc", 128'(instr_pc), 128'(m_pc));
        check_eq("err", 128'(err), 128'(m_err));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic push(input logic [63:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic pop(input logic [3:0] n);
        cycle(1'b0, 1'b0, '0, 1'b1, n, 1'b0, '0);
    endtask

    initial begin
        int wc;
        logic fv, cv, fl, rst;
        logic [3:0] cl;

        #2;
        do_reset();
        check_eq("rst_ready", 128'(fetch_ready), 128'(1));
        check_eq("rst_wcnt", 128'(window_count), 128'(0));
        check_eq("rst_window", window, 128'(0));

        // Single chunk after redirect, then legal and illegal consume.
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 64'h40_0000);
        push(64'h0000_0000_C305_8B48);
        check_eq("first_bytes", 128'(window[127:96]), 128'(32'h488B05C3));
        check_eq("first_pc", 128'(instr_pc), 128'(64'h40_0000));
        pop(4'd3);
        check_eq("c3_byte0", 128'(window[127:120]), 128'(8'hC3));
        check_eq("c3_pc", 128'(instr_pc), 128'(64'h40_0003));
        pop(4'd6);
        check_eq("illegal_err", 128'(err), 128'(1));
        check_eq("illegal_wcnt", 128'(window_count), 128'(5));

        // Fill to capacity, then consume while a chunk is held pending.
        do_reset();
        for (int i = 0; i < 4; i++) push({$urandom, $urandom});
        check_eq("full_ready", 128'(fetch_ready), 128'(0));
        cycle(1'b0, 1'b1, 64'h8877_6655_4433_2211, 1'b1, 4'd8, 1'b0, '0);
        cycle(1'b0, 1'b1, 64'h8877_6655_4433_2211, 1'b0, '0, 1'b0, '0);
        check_eq("tail_wrap", 128'(dut.tail_q), 128'(8));
        for (int i = 0; i < 4; i++) pop(4'd8);

        // Simultaneous enqueue and consume at count 24.
        do_reset();
        for (int i = 0; i < 3; i++) push({$urandom, $urandom});
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 4'd5, 1'b0, '0);
        check_eq("mix_wcnt", 128'(window_count), 128'(16));
        check_eq("mix_pc", 128'(instr_pc), 128'(5));

        // Flush wins over a same-cycle fetch and consume.
        do_reset();
        for (int i = 0; i < 3; i++) push({$urandom, $urandom});
        pop(4'd4);
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 4'd3, 1'b1, 64'h1000);
        check_eq("flush_wcnt", 128'(window_count), 128'(0));
        check_eq("flush_pc", 128'(instr_pc), 128'(64'h1000));
        idle();

        // Random stream.
        for (int n = 0; n < 3000; n++) begin
            wc  = exp_wcnt();
            rst = ($urandom_range(0, 299) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            fv  = ($urandom_range(0, 3) != 0);
            cv  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 59) == 0) begin
                cl = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'(($urandom_range(wc + 1, 15)));
                if (wc >= 15) cl = 4'd0;
            end else if (wc == 0) begin
                cv = 1'b0; cl = '0;
            end else begin
                cl = 4'($urandom_range(1, (wc > 15) ? 15 : wc));
            end
            cycle(rst, fv, {$urandom, $urandom}, cv, cl, fl,
                  {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
